// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU results (fixed priority) and valid/ready LSU/MULDIV
// results onto the single registered RegWEn/AddrD/DataD write port of the register array.
// LSU results displaced by ALU writes wait in a small FIFO; queued entries whose rd is
// overwritten by a younger ALU write are marked dead and popped without writing.
// Optional build macro: WB_PERF_EN adds perf_wr_cnt / perf_stall_cnt / perf_kill_cnt outputs.
module regfile_writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            RegWEn,
  output logic [4:0]      AddrD,
  output logic [XLEN-1:0] DataD,
  output logic [31:0]     pending_mask
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_wr_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_kill_cnt
`endif
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [4:0]            q_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]       q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_live;
  logic [FIFO_DEPTH-1:0] kill_vec;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W:0]        count;

  logic alu_wr;
  logic lsu_hs;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic drop;
  logic push;

  // Credit comes from occupancy only; a pop in the same cycle does not open a slot early.
  assign lsu_ready  = !rst && (count < DEPTH_C);
  assign lsu_hs     = lsu_valid && lsu_ready;
  assign alu_wr     = alu_valid && (alu_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign pop        = !alu_wr && !fifo_empty;
  assign bypass     = !alu_wr && fifo_empty && lsu_hs && (lsu_rd != 5'd0);
  // A same-cycle LSU result for the rd the ALU is writing is older, so it is dropped.
  assign drop       = lsu_hs && alu_wr && (lsu_rd == alu_rd);
  assign push       = lsu_hs && (lsu_rd != 5'd0) && !bypass && !drop;

  // Live queued entries overwritten by this cycle's ALU write.
  always_comb begin
    kill_vec = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      kill_vec[i] = alu_wr && q_live[i] && (q_rd[i] == alu_rd);
    end
  end

  // Pending-rd mask for decode stall: one bit per live queued destination, x0 never pending.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (q_live[i]) pending_mask[q_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // FIFO payload storage; contents are meaningless unless the live bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= lsu_rd;
      q_data[tail] <= lsu_data;
    end
  end

  // FIFO pointers, occupancy and live bits; pop clears so stale slots never show as pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      q_live <= q_live & ~kill_vec;
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        q_live[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Registered write port: ALU first, then FIFO head, then LSU bypass when nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
    end else if (alu_wr) begin
      RegWEn <= 1'b1;
      AddrD  <= alu_rd;
      DataD  <= alu_data;
    end else if (pop) begin
      RegWEn <= q_live[head];
      if (q_live[head]) begin
        AddrD <= q_rd[head];
        DataD <= q_data[head];
      end
    end else if (bypass) begin
      RegWEn <= 1'b1;
      AddrD  <= lsu_rd;
      DataD  <= lsu_data;
    end else begin
      RegWEn <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  logic        wr_fire;
  logic [31:0] kill_n;

  assign wr_fire = alu_wr || (pop && q_live[head]) || bypass;

  // Number of results discarded this cycle: queued entries killed plus a dropped handshake.
  always_comb begin
    kill_n = 32'(drop);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      kill_n = kill_n + 32'(kill_vec[i]);
    end
  end

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (wr_fire) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (lsu_valid && !lsu_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_kill_cnt <= perf_kill_cnt + kill_n;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed cycle-by-cycle scenarios, with
// every expected register write queued in a scoreboard and matched as RegWEn pulses appear.
module tb_regfile_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        RegWEn;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic [31:0] pending_mask;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];

  regfile_writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .RegWEn       (RegWEn),
    .AddrD        (AddrD),
    .DataD        (DataD),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // One cycle of stimulus, applied at the falling edge; returns 1 time unit later.
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    @(negedge clk);
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldat;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Scoreboard: every write the port performs must be the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && RegWEn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, AddrD, DataD}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 64'(AddrD), 64'(e.rd));
        chk("sb_data", 64'(DataD), 64'(e.data));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwen", 64'(RegWEn), 64'd0);
    chk("rst_addrd", 64'(AddrD), 64'd0);
    chk("rst_datad", 64'(DataD), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(lsu_ready), 64'd1);

    // ALU only
    expw(5'd5, 32'hA5A5A5A5);
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    idle();
    chk("alu_regwen", 64'(RegWEn), 64'd1);
    chk("alu_addrd", 64'(AddrD), 64'd5);
    chk("alu_datad", 64'(DataD), 64'hA5A5A5A5);
    idle();
    chk("alu_regwen_off", 64'(RegWEn), 64'd0);

    // Bypass
    expw(5'd7, 32'h11);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    chk("byp_ready", 64'(lsu_ready), 64'd1);
    idle();
    chk("byp_regwen", 64'(RegWEn), 64'd1);
    chk("byp_addrd", 64'(AddrD), 64'd7);
    chk("byp_datad", 64'(DataD), 64'h11);
    chk("byp_mask", 64'(pending_mask), 64'd0);
    idle();

    // Contention: ALU busy 4 cycles while the LSU offers three results
    expw(5'd1, 32'h101); expw(5'd1, 32'h102); expw(5'd1, 32'h103); expw(5'd1, 32'h104);
    expw(5'd8, 32'h22);  expw(5'd9, 32'h33);  expw(5'd10, 32'h44);
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h22);
    chk("cont_ready0", 64'(lsu_ready), 64'd1);
    drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd9, 32'h33);
    chk("cont_ready1", 64'(lsu_ready), 64'd1);
    chk("cont_mask1", 64'(pending_mask), 64'h100);
    drive(1'b1, 5'd1, 32'h103, 1'b1, 5'd10, 32'h44);
    chk("cont_ready2", 64'(lsu_ready), 64'd0);
    chk("cont_mask2", 64'(pending_mask), 64'h300);
    drive(1'b1, 5'd1, 32'h104, 1'b1, 5'd10, 32'h44);
    chk("cont_ready3", 64'(lsu_ready), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h44);
    chk("cont_ready4", 64'(lsu_ready), 64'd0);
    chk("cont_addr4", 64'(AddrD), 64'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h44);
    chk("cont_ready5", 64'(lsu_ready), 64'd1);
    chk("cont_x8", {31'd0, RegWEn, 27'd0, AddrD}, {31'd0, 1'b1, 27'd0, 5'd8});
    chk("cont_mask5", 64'(pending_mask), 64'h200);
    idle();
    chk("cont_x9", {31'd0, RegWEn, 27'd0, AddrD}, {31'd0, 1'b1, 27'd0, 5'd9});
    chk("cont_mask6", 64'(pending_mask), 64'h400);
    idle();
    chk("cont_x10", {31'd0, RegWEn, 27'd0, AddrD}, {31'd0, 1'b1, 27'd0, 5'd10});
    chk("cont_mask7", 64'(pending_mask), 64'd0);
    idle();
    chk("cont_done", 64'(RegWEn), 64'd0);
    chk("cont_sb_empty", 64'(exp_q.size()), 64'd0);

    // Stale kill: queued x3 overwritten by a younger ALU write to x3
    expw(5'd1, 32'h55); expw(5'd3, 32'h2);
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd3, 32'h1);
    drive(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0);
    chk("kill_mask_before", 64'(pending_mask), 64'h8);
    idle();
    chk("kill_mask_after", 64'(pending_mask), 64'd0);
    chk("kill_alu_data", 64'(DataD), 64'h2);
    idle();
    chk("kill_dead_pop", 64'(RegWEn), 64'd0);
    // Same-cycle LSU result for the ALU's rd is accepted and dropped
    expw(5'd4, 32'h77);
    drive(1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 32'h99);
    chk("drop_ready", 64'(lsu_ready), 64'd1);
    idle();
    chk("drop_data", 64'(DataD), 64'h77);
    idle();
    chk("drop_no_write", 64'(RegWEn), 64'd0);
    chk("drop_mask", 64'(pending_mask), 64'd0);
    chk("kill_sb_empty", 64'(exp_q.size()), 64'd0);

    // x0 destinations
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    idle();
    chk("x0_alu_nowrite", 64'(RegWEn), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
    chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
    idle();
    chk("x0_lsu_nowrite", 64'(RegWEn), 64'd0);
    chk("x0_lsu_mask", 64'(pending_mask), 64'd0);
    expw(5'd1, 32'h201); expw(5'd1, 32'h202); expw(5'd1, 32'h203);
    expw(5'd11, 32'h5); expw(5'd12, 32'h6);
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd0, 32'hDEAD);
    drive(1'b1, 5'd1, 32'h202, 1'b1, 5'd11, 32'h5);
    chk("x0_no_slot", 64'(lsu_ready), 64'd1);
    drive(1'b1, 5'd1, 32'h203, 1'b1, 5'd12, 32'h6);
    chk("x0_ready_one", 64'(lsu_ready), 64'd1);
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    chk("x0_mask", 64'(pending_mask), 64'h1800);
    idle();
    chk("x0_alu_pop", 64'(AddrD), 64'd11);
    idle();
    chk("x0_second_pop", 64'(AddrD), 64'd12);
    idle();
    chk("x0_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with two entries queued
    expw(5'd1, 32'h301); expw(5'd1, 32'h302);
    drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd13, 32'h7);
    drive(1'b1, 5'd1, 32'h302, 1'b1, 5'd14, 32'h8);
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h303;
    lsu_valid = 1'b1; lsu_rd = 5'd15; lsu_data = 32'h9;
    rst = 1'b1;
    #1;
    chk("mid_rst_regwen", 64'(RegWEn), 64'd0);
    chk("mid_rst_mask", 64'(pending_mask), 64'd0);
    chk("mid_rst_ready", 64'(lsu_ready), 64'd0);
    idle();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 64'(lsu_ready), 64'd1);
    repeat (4) idle();
    chk("mid_no_write", 64'(RegWEn), 64'd0);
    chk("mid_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
